// File: rtl/fft8_reorder.sv
// fft8_reorder: bit-reversed to natural-order ping-pong buffer, 8-point SDF FFT.
// Optional sticky protocol error flag under FFT8_REORDER_ERR_EN.
module fft8_reorder #(
  parameter int N_LOG2  = 3,
  parameter int DATA_WL = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_s,
  output logic               ready_s,
  input  logic [DATA_WL-1:0] data_s_r,
  input  logic [DATA_WL-1:0] data_s_i,
  output logic               valid_m,
  input  logic               ready_m,
  output logic [DATA_WL-1:0] data_m_r,
  output logic [DATA_WL-1:0] data_m_i,
  output logic               last_m
`ifdef FFT8_REORDER_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int DEPTH = 1 << N_LOG2;
  localparam int W     = 2 * DATA_WL;

  logic [W-1:0]      mem [2][DEPTH];
  logic [N_LOG2-1:0] wcnt;
  logic [N_LOG2-1:0] rcnt;
  logic [N_LOG2-1:0] wadr;
  logic              wb;
  logic              rb;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_acc;
  logic              wr_last;
  logic              advance;
  logic              rd_ld;
  logic              rd_last;
  logic [W-1:0]      rd_word;

  assign ready_s = !full[wb];
  assign wr_acc  = valid_s && ready_s;
  assign wr_last = wr_acc && (&wcnt);
  assign advance = !valid_m || ready_m;
  assign rd_ld   = advance && full[rb];
  assign rd_last = rd_ld && (&rcnt);
  assign rd_word = mem[rb][rcnt];

  always_comb begin
    wadr = '0;
    for (int i = 0; i < N_LOG2; i++) begin
      wadr[i] = wcnt[N_LOG2-1-i];
    end
  end

  // Set and clear always hit different banks, so both apply.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wb] = 1'b1;
    if (rd_last) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wb][wadr] <= {data_s_r, data_s_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      wb   <= 1'b0;
      full <= '0;
    end else begin
      full <= full_nxt;
      if (wr_acc) begin
        wcnt <= wcnt + 1'b1;
        if (wr_last) wb <= !wb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt     <= '0;
      rb       <= 1'b0;
      valid_m  <= 1'b0;
      last_m   <= 1'b0;
      data_m_r <= '0;
      data_m_i <= '0;
    end else if (advance) begin
      if (rd_ld) begin
        data_m_r <= rd_word[W-1:DATA_WL];
        data_m_i <= rd_word[DATA_WL-1:0];
        valid_m  <= 1'b1;
        last_m   <= &rcnt;
        rcnt     <= rcnt + 1'b1;
        if (rd_last) rb <= !rb;
      end else begin
        valid_m <= 1'b0;
        last_m  <= 1'b0;
      end
    end
  end

`ifdef FFT8_REORDER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (valid_s && !ready_s) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft8_reorder.sv
// tb_fft8_reorder: random stimulus vs frame-level queue model.
// Checks reset, ordering, streaming, backpressure, stalls, mid-frame reset.
module tb_fft8_reorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_s;
  logic        ready_s;
  logic [13:0] data_s_r;
  logic [13:0] data_s_i;
  logic        valid_m;
  logic        ready_m;
  logic [13:0] data_m_r;
  logic [13:0] data_m_i;
  logic        last_m;
`ifdef FFT8_REORDER_ERR_EN
  logic        err;
`endif

  fft8_reorder #(.N_LOG2(3), .DATA_WL(14)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_s(valid_s),
    .ready_s(ready_s),
    .data_s_r(data_s_r),
    .data_s_i(data_s_i),
    .valid_m(valid_m),
    .ready_m(ready_m),
    .data_m_r(data_m_r),
    .data_m_i(data_m_i),
    .last_m(last_m)
`ifdef FFT8_REORDER_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = !clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: arrival buffer, natural-order words of completed frames,
  // output register.
  logic [27:0] partial[$];
  logic [27:0] fq[$];
  logic        m_valid;
  logic        m_last;
  logic [27:0] m_data;
  logic        m_err;

  function automatic int bitrev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // A frame holds a bank until its final word has been loaded.
  function automatic logic m_rdy();
    return ((fq.size() + 7) / 8) < 2;
  endfunction

  function automatic void model_reset();
    partial.delete();
    fq.delete();
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_edge();
    logic acc;
    acc = valid_s && m_rdy();
    if (valid_s && !m_rdy()) m_err = 1'b1;
    if (!m_valid || ready_m) begin
      if (fq.size() > 0) begin
        m_last  = (fq.size() % 8) == 1;
        m_data  = fq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
    end
    if (acc) begin
      partial.push_back({data_s_r, data_s_i});
      if (partial.size() == 8) begin
        for (int k = 0; k < 8; k++) fq.push_back(partial[bitrev(k)]);
        partial.delete();
      end
    end
  endfunction

  task automatic step(input logic v, input logic [13:0] r,
                      input logic [13:0] i, input logic rm);
    valid_s  = v;
    data_s_r = r;
    data_s_i = i;
    ready_m  = rm;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    valid_s = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ready_m = 1'b1;
    valid_s = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !== {1'b1, 1'b0, 1'b0, 28'd0}) begin
      n_bad++;
      $display("FAIL reset: got rdy=%b v=%b l=%b r=%h i=%h, want 1 0 0 0 0",
               ready_s, valid_m, last_m, data_m_r, data_m_i);
    end
`ifdef FFT8_REORDER_ERR_EN
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int arr[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int first = -1;
    int nout = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) step(1'b1, 14'(arr[c]), 14'(-arr[c]), 1'b1);
      else step(1'b0, 14'h0, 14'h0, 1'b1);
      n_vec++;
      if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !==
          {m_rdy(), m_valid, m_last, m_data}) begin
        n_bad++;
        $display("FAIL single c=%0d: got %b %b %b %h %h want %b %b %b %h",
                 c, ready_s, valid_m, last_m, data_m_r, data_m_i,
                 m_rdy(), m_valid, m_last, m_data);
      end
      if (valid_m) begin
        if (first < 0) first = c;
        n_vec++;
        if (data_m_r !== 14'(nout) || data_m_i !== 14'(-nout) ||
            last_m !== (nout == 7)) begin
          n_bad++;
          $display("FAIL single_order: got r=%0d i=%h l=%b want r=%0d l=%b",
                   data_m_r, data_m_i, last_m, nout, nout == 7);
        end
        nout++;
      end
    end
    n_vec++;
    if (first != 8 || nout != 8) begin
      n_bad++;
      $display("FAIL single_latency: got first=%0d n=%0d want first=8 n=8", first, nout);
    end
  endtask

  task automatic test_stream();
    int nrdy0 = 0;
    int nout = 0;
    for (int c = 0; c < 44; c++) begin
      if (c < 32) step(1'b1, 14'($urandom), 14'($urandom), 1'b1);
      else step(1'b0, 14'h0, 14'h0, 1'b1);
      if (!ready_s) nrdy0++;
      if (valid_m) nout++;
      n_vec++;
      if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !==
          {m_rdy(), m_valid, m_last, m_data}) begin
        n_bad++;
        $display("FAIL stream c=%0d: got %b %b %b %h %h want %b %b %b %h",
                 c, ready_s, valid_m, last_m, data_m_r, data_m_i,
                 m_rdy(), m_valid, m_last, m_data);
      end
    end
    n_vec++;
    if (nrdy0 != 0 || nout != 32) begin
      n_bad++;
      $display("FAIL stream_rate: got stalls=%0d outs=%0d want 0 32", nrdy0, nout);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 45; c++) begin
      if (c < 17) step(1'b1, 14'($urandom), 14'($urandom), 1'b0);
      else step(1'b0, 14'h0, 14'h0, c >= 22);
      if (c == 16) begin
        n_vec++;
        if (ready_s !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_full: got ready_s=%b want 0", ready_s);
        end
`ifdef FFT8_REORDER_ERR_EN
        n_vec++;
        if (err !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_err: got %b want 1", err);
        end
`endif
      end
      n_vec++;
      if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !==
          {m_rdy(), m_valid, m_last, m_data}) begin
        n_bad++;
        $display("FAIL bp c=%0d: got %b %b %b %h %h want %b %b %b %h",
                 c, ready_s, valid_m, last_m, data_m_r, data_m_i,
                 m_rdy(), m_valid, m_last, m_data);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] pat = 16'b1111_1100_1101_1001;
    for (int c = 0; c < 30; c++) begin
      if (c < 8) step(1'b1, 14'($urandom), 14'($urandom), 1'b1);
      else if (c < 24) step(1'b0, 14'h0, 14'h0, pat[c-8]);
      else step(1'b0, 14'h0, 14'h0, 1'b1);
      n_vec++;
      if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !==
          {m_rdy(), m_valid, m_last, m_data}) begin
        n_bad++;
        $display("FAIL stall c=%0d: got %b %b %b %h %h want %b %b %b %h",
                 c, ready_s, valid_m, last_m, data_m_r, data_m_i,
                 m_rdy(), m_valid, m_last, m_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) step(1'b1, 14'($urandom), 14'($urandom), 1'b1);
    do_reset();
    n_vec++;
    if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !== {1'b1, 1'b0, 1'b0, 28'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: got %b %b %b %h %h want 1 0 0 0 0",
               ready_s, valid_m, last_m, data_m_r, data_m_i);
    end
`ifdef FFT8_REORDER_ERR_EN
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_err: got %b want 0", err);
    end
`endif
    for (int c = 0; c < 20; c++) begin
      if (c < 8) step(1'b1, 14'($urandom), 14'($urandom), 1'b1);
      else step(1'b0, 14'h0, 14'h0, 1'b1);
      n_vec++;
      if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !==
          {m_rdy(), m_valid, m_last, m_data}) begin
        n_bad++;
        $display("FAIL mid c=%0d: got %b %b %b %h %h want %b %b %b %h",
                 c, ready_s, valid_m, last_m, data_m_r, data_m_i,
                 m_rdy(), m_valid, m_last, m_data);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, 14'($urandom), 14'($urandom), ($urandom % 3) != 0);
      n_vec++;
      if ({ready_s, valid_m, last_m, data_m_r, data_m_i} !==
          {m_rdy(), m_valid, m_last, m_data}) begin
        n_bad++;
        $display("FAIL random c=%0d: got %b %b %b %h %h want %b %b %b %h",
                 c, ready_s, valid_m, last_m, data_m_r, data_m_i,
                 m_rdy(), m_valid, m_last, m_data);
      end
`ifdef FFT8_REORDER_ERR_EN
      n_vec++;
      if (err !== m_err) begin
        n_bad++;
        $display("FAIL random_err c=%0d: got %b want %b", c, err, m_err);
      end
`endif
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_s  = 1'b0;
    ready_m  = 1'b1;
    data_s_r = '0;
    data_s_i = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_stream();
    test_backpressure();
    test_stall();
    test_reset_mid();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
